pe_conv_ctrl: RTL
=================

// Module: pe_conv_ctrl
// PURPOSE
//  Sequencer for one 1-D Eyeriss-style PE row convolution.
//  - Loads filter taps, then one ifmap row, into the PE scratchpads.
//  - Sweeps the filter window across the row at a programmable stride, driving one MAC per tap.
//  - Hands each finished psum downstream over a valid/ready handshake.
//  - Sits between the PE input FIFOs and the scratchpad/MAC datapath; owns all spad addressing.
// PARAMETERS
//  ADDR_W  4  spad address width; each spad depth = 2**ADDR_W
//  OUT_W   5  width of psum output index
// PORTS
//  clk          in   1         clock; all state changes on posedge
//  rst          in   1         asynchronous, active-high reset
//  start        in   1         begin job; sampled only in IDLE
//  filter_size  in   ADDR_W    taps per filter, 1..2**ADDR_W-1
//  stride       in   ADDR_W    window step, 1..2**ADDR_W-1
//  ifmap_len    in   ADDR_W+1  ifmap row length, 1..2**ADDR_W
//  f_valid      in   1         filter word available
//  f_ready      out  1         filter load accepted this cycle when f_valid=1
//  f_we         out  1         write filter spad at f_addr (= f_valid & f_ready)
//  f_addr       out  ADDR_W    filter spad address (write in LOAD_F, read in MAC)
//  i_valid      in   1         ifmap word available
//  i_ready      out  1         ifmap load accepted this cycle when i_valid=1
//  i_we         out  1         write ifmap spad at i_addr (= i_valid & i_ready)
//  i_addr       out  ADDR_W    ifmap spad address (write in LOAD_I, read in MAC)
//  mac_en       out  1         multiply f_spad[f_addr]*i_spad[i_addr] into accumulator
//  mac_clr      out  1         with mac_en: accumulator := product (first tap)
//  psum_valid   out  1         accumulator holds finished psum
//  psum_ready   in   1         downstream accepts psum
//  out_idx      out  OUT_W     index of current psum, 0-based
//  busy         out  1         high in every state except IDLE
//  done         out  1         one-cycle pulse after the last psum handshake
//  err          out  1         one-cycle pulse on rejected config
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; internal counters, base and latched config cleared.
//  - Config check on start in IDLE:
//    - Reject if filter_size==0, stride==0, ifmap_len==0, or filter_size>ifmap_len.
//    - On reject: err=1 for the next cycle, state stays IDLE, busy stays 0.
//    - On accept: latch filter_size/stride/ifmap_len, go to LOAD_F.
//    - Config inputs are ignored while busy.
//  - Handshake rule: a word transfers on a cycle with valid & ready. psum_ready may be high before psum_valid.
//  - FSM: IDLE -> LOAD_F -> LOAD_I -> MAC <-> WRITE -> DONE -> IDLE.
//  - LOAD_F: f_ready=1.
//    - f_addr counts 0..filter_size-1, advancing only on a handshake.
//    - Handshake at filter_size-1 moves to LOAD_I.
//  - LOAD_I: i_ready=1.
//    - i_addr counts 0..ifmap_len-1, advancing only on a handshake.
//    - Handshake at ifmap_len-1 moves to MAC, with base=0 and out_idx=0.
//  - MAC: exactly filter_size cycles, no stalls.
//    - Tap k: mac_en=1, f_addr=k, i_addr=base+k; mac_clr=1 only at k=0.
//    - After the last tap, go to WRITE.
//  - WRITE: psum_valid=1; out_idx stable; mac_en=0. Hold until psum_ready.
//    - On handshake: next_base = base+stride.
//    - Compare next_base+filter_size against ifmap_len in ADDR_W+2 bits (no wrap).
//    - If <= ifmap_len: base=next_base, out_idx++, go to MAC. Otherwise go to DONE.
//  - DONE: done=1 for one cycle, busy=1, then IDLE. start in DONE is ignored.
//  - Psum count: floor((ifmap_len-filter_size)/stride)+1. out_idx wraps mod 2**OUT_W (not flagged).
//  - Address and strobe outputs are 0 in states that do not use them.
//  - Async rst at any point: outputs 0 immediately; partial job discarded.
// TESTING
//  - fs=3, st=1, len=5, all valid/ready=1, start at cycle 0:
//    LOAD_F cycles 1-3, LOAD_I 4-8; psums idx 0,1,2; done at cycle 21.
//    MAC i_addr sequence 0,1,2 / 1,2,3 / 2,3,4.
//  - fs=3, st=2, len=8: bases 0,2,4; exactly 3 psums (base 6 rejected since 9>8); done follows idx 2.
//  - Backpressure: psum_ready=0 for 4 cycles in WRITE -> psum_valid held, out_idx stable, mac_en=0;
//    proceeds the cycle after ready rises.
//  - f_valid pattern 1,0,1,0,1 with fs=3 -> f_we only on valid cycles, f_addr 0,1,2; LOAD_I entered after the 3rd write.
//  - Config errors: fs=0 -> err pulse, busy=0. fs=5,len=4 -> err pulse.
//    Then a valid start runs normally.
//  - Assert rst during MAC tap 1 -> all outputs 0 without a clock edge.
//    Release, then start fs=1, st=1, len=2 -> psums idx 0,1, then done.

Source files
------------

// File: rtl/pe_conv_ctrl.sv
// Sequencer for one 1-D PE row convolution: loads filter taps and one ifmap row
// into the scratchpads, sweeps the window at a programmable stride, and hands each psum downstream.
module pe_conv_ctrl #(
    parameter int ADDR_W = 4,
    parameter int OUT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] filter_size,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ADDR_W:0]   ifmap_len,
    input  logic              f_valid,
    output logic              f_ready,
    output logic              f_we,
    output logic [ADDR_W-1:0] f_addr,
    input  logic              i_valid,
    output logic              i_ready,
    output logic              i_we,
    output logic [ADDR_W-1:0] i_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              psum_valid,
    input  logic              psum_ready,
    output logic [OUT_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_F = 3'd1;
    localparam logic [2:0] S_LOAD_I = 3'd2;
    localparam logic [2:0] S_MAC    = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] icnt_q, icnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OUT_W-1:0]  oidx_q, oidx_d;
    logic [ADDR_W-1:0] fs_q, fs_d;
    logic [ADDR_W-1:0] st_q, st_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              err_q, err_d;

    logic              cfg_bad;
    logic              last_f;
    logic              last_i;
    logic [ADDR_W+1:0] next_base;
    logic [ADDR_W+1:0] win_end;
    logic              win_fits;

    assign cfg_bad = (filter_size == '0) || (stride == '0) || (ifmap_len == '0) ||
                     ({1'b0, filter_size} > ifmap_len);

    // fcnt serves as the filter write pointer in LOAD_F and the tap index in MAC
    assign last_f = (fcnt_q == fs_q - {{(ADDR_W-1){1'b0}}, 1'b1});
    assign last_i = ({1'b0, icnt_q} == len_q - {{ADDR_W{1'b0}}, 1'b1});

    // Window-end check is done two bits wider so base+stride+fs never wraps
    assign next_base = {2'b00, base_q} + {2'b00, st_q};
    assign win_end   = next_base + {2'b00, fs_q};
    assign win_fits  = (win_end <= {1'b0, len_q});

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        icnt_d  = icnt_q;
        base_d  = base_q;
        oidx_d  = oidx_q;
        fs_d    = fs_q;
        st_d    = st_q;
        len_d   = len_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        fs_d    = filter_size;
                        st_d    = stride;
                        len_d   = ifmap_len;
                        fcnt_d  = '0;
                        icnt_d  = '0;
                        state_d = S_LOAD_F;
                    end
                end
            end
            S_LOAD_F: begin
                if (f_valid) begin
                    if (last_f) begin
                        fcnt_d  = '0;
                        state_d = S_LOAD_I;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_I: begin
                if (i_valid) begin
                    if (last_i) begin
                        icnt_d  = '0;
                        base_d  = '0;
                        oidx_d  = '0;
                        state_d = S_MAC;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                if (last_f) begin
                    fcnt_d  = '0;
                    state_d = S_WRITE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (psum_ready) begin
                    if (win_fits) begin
                        base_d  = next_base[ADDR_W-1:0];
                        oidx_d  = oidx_q + 1'b1;
                        state_d = S_MAC;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            icnt_q  <= '0;
            base_q  <= '0;
            oidx_q  <= '0;
            fs_q    <= '0;
            st_q    <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            icnt_q  <= icnt_d;
            base_q  <= base_d;
            oidx_q  <= oidx_d;
            fs_q    <= fs_d;
            st_q    <= st_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once
    always_comb begin
        f_ready    = (state_q == S_LOAD_F);
        f_we       = f_ready & f_valid;
        i_ready    = (state_q == S_LOAD_I);
        i_we       = i_ready & i_valid;
        mac_en     = (state_q == S_MAC);
        mac_clr    = mac_en && (fcnt_q == '0);
        psum_valid = (state_q == S_WRITE);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        err        = err_q;
        f_addr     = (f_ready || mac_en) ? fcnt_q : '0;
        if (i_ready)     i_addr = icnt_q;
        else if (mac_en) i_addr = base_q + fcnt_q;
        else             i_addr = '0;
        out_idx    = (mac_en || psum_valid) ? oidx_q : '0;
    end

endmodule
